// File: rtl/ej32_dstack.sv
// Data stack: 32-bit LIFO with registered top-of-stack (s) and entry count (depth).
// Define EJ32_DSTACK_GUARD_EN to drop overflow/underflow ops and flag them on err.
module ej32_dstack #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    op,
    input  logic [31:0]   vi,
    output logic [31:0]   s,
    output logic [AW:0]   depth,
    output logic          empty,
    output logic          full,
    output logic          err
);
    localparam logic [2:0]    OP_PUSH = 3'd1;
    localparam logic [2:0]    OP_POP  = 3'd2;
    localparam logic [2:0]    OP_REPL = 3'd3;
    localparam logic [2:0]    OP_CLR  = 3'd4;
    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_TWO = AW'(2);

    logic [31:0]   mem [DEPTH];
    logic [AW:0]   sp, sp_next;
    logic [31:0]   s_next, rd_data;
    logic          push_req, pop_req, wr_en;
    logic [AW-1:0] wr_addr;

    // REPL on an empty stack has nothing to overwrite, so it becomes a push.
    assign push_req = (op == OP_PUSH) || ((op == OP_REPL) && empty);
    assign pop_req  = (op == OP_POP);
    assign rd_data  = mem[sp[AW-1:0] - PTR_TWO];
    assign depth    = sp;
    assign empty    = (sp == '0);

`ifdef EJ32_DSTACK_GUARD_EN
    localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};
    logic err_q, err_next;
    assign full = (sp == SP_FULL);
    assign err  = err_q;
`else
    assign full = 1'b0;
    assign err  = 1'b0;
`endif

    always_comb begin
        sp_next = sp;
        s_next  = s;
        wr_en   = 1'b0;
        wr_addr = sp[AW-1:0];
`ifdef EJ32_DSTACK_GUARD_EN
        err_next = err_q;
`endif
        if (push_req) begin
`ifdef EJ32_DSTACK_GUARD_EN
            if (full) begin
                err_next = 1'b1;
            end else begin
                wr_en   = 1'b1;
                s_next  = vi;
                sp_next = sp + SP_ONE;
            end
`else
            wr_en   = 1'b1;
            s_next  = vi;
            sp_next = {1'b0, sp[AW-1:0] + PTR_ONE};
`endif
        end else if (pop_req) begin
`ifdef EJ32_DSTACK_GUARD_EN
            if (empty) begin
                err_next = 1'b1;
            end else begin
                sp_next = sp - SP_ONE;
                s_next  = (sp == SP_ONE) ? '0 : rd_data;
            end
`else
            sp_next = {1'b0, sp[AW-1:0] - PTR_ONE};
            s_next  = (sp == SP_ONE) ? '0 : rd_data;
`endif
        end else if (op == OP_REPL) begin
            wr_en   = 1'b1;
            wr_addr = sp[AW-1:0] - PTR_ONE;
            s_next  = vi;
        end else if (op == OP_CLR) begin
            sp_next = '0;
            s_next  = '0;
`ifdef EJ32_DSTACK_GUARD_EN
            err_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
            s  <= '0;
`ifdef EJ32_DSTACK_GUARD_EN
            err_q <= 1'b0;
`endif
        end else begin
            sp <= sp_next;
            s  <= s_next;
`ifdef EJ32_DSTACK_GUARD_EN
            err_q <= err_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_addr] <= vi;
        end
    end
endmodule

// File: tb/tb_ej32_dstack.sv
// Self-checking bench for ej32_dstack; expectations queued per op, compared one cycle later.
module tb_ej32_dstack;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] vi;
    logic [31:0] s;
    logic [6:0]  depth;
    logic        empty, full, err;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [31:0] s;
        logic [6:0]  depth;
        logic        empty;
        logic        full;
        logic        err;
        logic        chk_s;
    } exp_t;

    exp_t sb[$];

    ej32_dstack dut (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .vi   (vi),
        .s    (s),
        .depth(depth),
        .empty(empty),
        .full (full),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] sv, input int d, input logic e, input logic cs);
        exp_t x;
        x.s     = sv;
        x.depth = 7'(d);
        x.empty = (d == 0);
`ifdef EJ32_DSTACK_GUARD_EN
        x.full  = (d == 64);
`else
        x.full  = 1'b0;
`endif
        x.err   = e;
        x.chk_s = cs;
        return x;
    endfunction

    task automatic drive(input logic r, input int o, input logic [31:0] v);
        @(negedge clk);
        rst = r;
        op  = 3'(o);
        vi  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(32'h0, 0, 1'b0, 1'b1));
            drive(1'b0, 1, 32'h99);
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL reset[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask

    task automatic test_push_pop();
        int ops [6] = '{1, 1, 1, 2, 2, 2};
        int vis [6] = '{'h11, 'h22, 'h33, 0, 0, 0};
        int es  [6] = '{'h11, 'h22, 'h33, 'h22, 'h11, 0};
        int ed  [6] = '{1, 2, 3, 2, 1, 0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'b0, 1'b1));
            drive(1'b1, ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL push_pop[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask

    task automatic test_repl();
        int ops [3] = '{1, 3, 2};
        int vis [3] = '{'hA, 'hB, 0};
        int es  [3] = '{'hA, 'hB, 0};
        int ed  [3] = '{1, 1, 0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'b0, 1'b1));
            drive(1'b1, ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL repl[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        int ops [13] = '{4, 1, 1, 2, 1, 2, 0, 7, 5, 3, 1, 2, 2};
        int vis [13] = '{0, 1, 2, 0, 3, 0, 9, 9, 9, 4, 5, 0, 0};
        int es  [13] = '{0, 1, 2, 1, 3, 1, 1, 1, 1, 4, 5, 4, 0};
        int ed  [13] = '{0, 1, 2, 1, 2, 1, 1, 1, 1, 1, 2, 1, 0};
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'b0, 1'b1));
            drive(1'b1, ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL back_to_back[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask

`ifdef EJ32_DSTACK_GUARD_EN
    task automatic test_guard();
        int ops [6] = '{1, 3, 4, 2, 3, 4};
        int vis [6] = '{'hDEAD, 'hBEEF, 0, 0, 7, 0};
        int es  [6] = '{'h13F, 'hBEEF, 0, 0, 7, 0};
        int ed  [6] = '{64, 64, 0, 0, 1, 0};
        int ee  [6] = '{1, 1, 0, 1, 1, 0};
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            sb.push_back(mk(32'h100 + 32'(i), i + 1, 1'b0, 1'b1));
            drive(1'b1, 1, 32'h100 + 32'(i));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL guard_fill[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
        for (int i = 0; i < 6; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'(ee[i]), 1'b1));
            drive(1'b1, ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL guard[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask
`else
    task automatic test_wrap();
        // s after a pop that wraps below empty comes from unwritten memory, so it is not checked.
        int ops [8] = '{4, 2, 1, 2, 4, 1, 2, 4};
        int vis [8] = '{0, 0, 5, 0, 0, 5, 0, 0};
        int es  [8] = '{0, 0, 5, 0, 0, 5, 0, 0};
        int ed  [8] = '{0, 63, 0, 63, 0, 1, 0, 0};
        int cs  [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'b0, 1'(cs[i])));
            drive(1'b1, ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL wrap[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
        for (int i = 0; i < 65; i++) begin
            sb.push_back(mk(32'(i + 1), (i + 1) % 64, 1'b0, 1'b1));
            drive(1'b1, 1, 32'(i + 1));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL wrap_fill[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
        drive(1'b1, 4, 32'h0);
    endtask
`endif

    task automatic test_reset_mid();
        int rs  [6] = '{1, 1, 0, 1, 1, 1};
        int ops [6] = '{1, 1, 1, 0, 1, 2};
        int vis [6] = '{'h77, 'h88, 'h99, 0, 1, 0};
        int es  [6] = '{'h77, 'h88, 0, 0, 1, 0};
        int ed  [6] = '{1, 2, 0, 0, 1, 0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(mk(32'(es[i]), ed[i], 1'b0, 1'b1));
            drive(1'(rs[i]), ops[i], 32'(vis[i]));
            e = sb.pop_front();
            checks_total++;
            if ((e.chk_s && s !== e.s) || depth !== e.depth || empty !== e.empty || full !== e.full || err !== e.err)
                $display("FAIL reset_mid[%0d]: got s=%h depth=%0d empty=%b full=%b err=%b, want s=%h depth=%0d empty=%b full=%b err=%b",
                         i, s, depth, empty, full, err, e.s, e.depth, e.empty, e.full, e.err);
            else checks_passed++;
        end
    endtask

    initial begin
        rst = 1'b0;
        op  = 3'd0;
        vi  = 32'h0;
        test_reset();
        test_push_pop();
        test_repl();
        test_back_to_back();
`ifdef EJ32_DSTACK_GUARD_EN
        test_guard();
`else
        test_wrap();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
